// File: rtl/axi_rd_arbiter_if.sv
// Signal bundle between the read-path arbiter and the masters/slave it sits between.
// The slave modport is the arbiter's view; the master modport is the driving side's view.
interface axi_rd_arbiter_if;
  logic       m0_arvalid;
  logic       m1_arvalid;
  logic       m2_arvalid;
  logic       m_arready;
  logic       m_rvalid;
  logic       m_rlast;
  logic       s_rready;
  logic [2:0] rd_grant;
  logic       rd_busy;
  logic       rd_timeout;

  modport slave (
    input  m0_arvalid,
    input  m1_arvalid,
    input  m2_arvalid,
    input  m_arready,
    input  m_rvalid,
    input  m_rlast,
    input  s_rready,
    output rd_grant,
    output rd_busy,
    output rd_timeout
  );

  modport master (
    output m0_arvalid,
    output m1_arvalid,
    output m2_arvalid,
    output m_arready,
    output m_rvalid,
    output m_rlast,
    output s_rready,
    input  rd_grant,
    input  rd_busy,
    input  rd_timeout
  );
endinterface

// File: rtl/axi_rd_arbiter.sv
// Round-robin read-path arbiter for three masters: holds a one-hot grant from arbitration
// to the last R beat, with a watchdog that releases a grant stalled without AR/R progress.
module axi_rd_arbiter #(
  parameter int TIMEOUT_CYC = 256,
  parameter int CNT_WIDTH   = 16
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  axi_rd_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam bit                   WD_EN   = (TIMEOUT_CYC != 0);
  localparam logic [CNT_WIDTH-1:0] WD_LAST = CNT_WIDTH'(WD_EN ? TIMEOUT_CYC - 1 : 0);
  localparam logic [CNT_WIDTH-1:0] WD_MAX  = '1;

  state_t               state_reg, state_next;
  logic [2:0]           grant_reg, grant_next;
  logic [2:0]           last_grant_reg, last_grant_next;
  logic [CNT_WIDTH-1:0] wd_cnt_reg, wd_cnt_next;
  logic                 busy_reg;
  logic                 timeout_reg, timeout_next;

  logic [2:0] arvalid_vec;
  logic [2:0] sel_vec;
  logic [2:0] pick;
  logic       sel_arvalid;
  logic       ar_hs;
  logic       r_hs;
  logic       any_hs;
  logic       wd_expired;

  assign arvalid_vec = {bus.m2_arvalid, bus.m1_arvalid, bus.m0_arvalid};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_sel
      assign sel_vec[gi] = grant_reg[gi] & arvalid_vec[gi];
    end
  endgenerate

  assign sel_arvalid = |sel_vec;
  assign ar_hs       = sel_arvalid & bus.m_arready;
  assign r_hs        = bus.m_rvalid & bus.s_rready;
  assign any_hs      = ar_hs | r_hs;
  // Any handshake in the expiry cycle counts as progress and suppresses the release.
  assign wd_expired  = WD_EN && (wd_cnt_reg == WD_LAST) && !any_hs;

  // Search starts just after the previous owner, wrapping 0 -> 1 -> 2 -> 0.
  always_comb begin
    pick = 3'b000;
    case (last_grant_reg)
      3'b001: begin
        if (arvalid_vec[1])      pick = 3'b010;
        else if (arvalid_vec[2]) pick = 3'b100;
        else if (arvalid_vec[0]) pick = 3'b001;
      end
      3'b010: begin
        if (arvalid_vec[2])      pick = 3'b100;
        else if (arvalid_vec[0]) pick = 3'b001;
        else if (arvalid_vec[1]) pick = 3'b010;
      end
      default: begin
        if (arvalid_vec[0])      pick = 3'b001;
        else if (arvalid_vec[1]) pick = 3'b010;
        else if (arvalid_vec[2]) pick = 3'b100;
      end
    endcase
  end

  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    last_grant_next = last_grant_reg;
    wd_cnt_next     = wd_cnt_reg;
    timeout_next    = 1'b0;

    case (state_reg)
      IDLE: begin
        grant_next  = 3'b000;
        wd_cnt_next = '0;
        if (|arvalid_vec) begin
          grant_next = pick;
          state_next = ADDR;
        end
      end

      ADDR, DATA: begin
        if (any_hs) begin
          wd_cnt_next = '0;
        end else if (wd_cnt_reg != WD_MAX) begin
          wd_cnt_next = wd_cnt_reg + 1'b1;
        end

        if (state_reg == ADDR && ar_hs) begin
          state_next = DATA;
        end else if (state_reg == DATA && r_hs && bus.m_rlast) begin
          grant_next      = 3'b000;
          last_grant_next = grant_reg;
          wd_cnt_next     = '0;
          state_next      = IDLE;
        end else if (wd_expired) begin
          grant_next      = 3'b000;
          last_grant_next = grant_reg;
          wd_cnt_next     = '0;
          timeout_next    = 1'b1;
          state_next      = IDLE;
        end
      end

      default: begin
        grant_next  = 3'b000;
        wd_cnt_next = '0;
        state_next  = IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_reg      <= IDLE;
      grant_reg      <= 3'b000;
      last_grant_reg <= 3'b100;
      wd_cnt_reg     <= '0;
      busy_reg       <= 1'b0;
      timeout_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
      wd_cnt_reg     <= wd_cnt_next;
      busy_reg       <= |grant_next;
      timeout_reg    <= timeout_next;
    end
  end

  assign bus.rd_grant   = grant_reg;
  assign bus.rd_busy    = busy_reg;
  assign bus.rd_timeout = timeout_reg;

endmodule
